// File: rtl/nfca_poll_scheduler_if.sv
// rtl/nfca_poll_scheduler_if.sv - host, controller TX/RX and uart pass-through signal bundle
interface nfca_poll_scheduler_if;
    logic       poll_en;
    logic       h_tvalid;
    logic       h_tready;
    logic [7:0] h_tdata;
    logic [3:0] h_tdatab;
    logic       h_tlast;
    logic       tx_tvalid;
    logic       tx_tready;
    logic [7:0] tx_tdata;
    logic [3:0] tx_tdatab;
    logic       tx_tlast;
    logic       rx_tvalid;
    logic [7:0] rx_tdata;
    logic [3:0] rx_tdatab;
    logic       rx_tend;
    logic       rx_terr;
    logic       o_tvalid;
    logic [7:0] o_tdata;
    logic [3:0] o_tdatab;
    logic       o_tend;
    logic       o_terr;
    logic       card_present;
    logic       busy;

    modport slave (
        input  poll_en, h_tvalid, h_tdata, h_tdatab, h_tlast,
        output h_tready,
        output tx_tvalid, tx_tdata, tx_tdatab, tx_tlast,
        input  tx_tready,
        input  rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr,
        output o_tvalid, o_tdata, o_tdatab, o_tend, o_terr,
        output card_present, busy
    );

    modport master (
        output poll_en, h_tvalid, h_tdata, h_tdatab, h_tlast,
        input  h_tready,
        input  tx_tvalid, tx_tdata, tx_tdatab, tx_tlast,
        output tx_tready,
        output rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr,
        input  o_tvalid, o_tdata, o_tdatab, o_tend, o_terr,
        input  card_present, busy
    );
endinterface

// File: rtl/nfca_poll_scheduler.sv
// rtl/nfca_poll_scheduler.sv - arbitrates controller TX between host frames and REQA presence polls
module nfca_poll_scheduler #(
    parameter int unsigned CLK_FREQ     = 81360000,
    parameter int unsigned POLL_MS      = 100,
    parameter int unsigned RESP_TIMEOUT = 40000,
    parameter int unsigned MISS_LIMIT   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    nfca_poll_scheduler_if.slave   bus
);

    localparam int unsigned POLL_CYC = CLK_FREQ / 1000 * POLL_MS;
    localparam int PW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int WW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYC - 1);
    localparam logic [WW-1:0] WAIT_RELOAD = WW'(RESP_TIMEOUT - 1);
    localparam logic [3:0]    MISS_MAX    = 4'(MISS_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_TX,
        S_HOST_WAIT,
        S_POLL_TX,
        S_POLL_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
    logic            poll_due_q, poll_due_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]      miss_cnt_q, miss_cnt_d;
    logic            card_present_q, card_present_d;
    logic [2:0]      rx_cnt_q, rx_cnt_d;
    logic            rx_bad_q, rx_bad_d;
    logic            o_tvalid_q, o_tvalid_d;
    logic [7:0]      o_tdata_q, o_tdata_d;
    logic [3:0]      o_tdatab_q, o_tdatab_d;
    logic            o_tend_q, o_tend_d;
    logic            o_terr_q, o_terr_d;

    logic            tx_tvalid, tx_tlast, h_tready;
    logic [7:0]      tx_tdata;
    logic [3:0]      tx_tdatab;
    logic            rx_end, rx_byte, wait_done, poll_ok;
    logic [3:0]      miss_next;

    // Next-state, timers, poll bookkeeping and the TX mux
    always_comb begin
        state_d        = state_q;
        poll_cnt_d     = poll_cnt_q;
        poll_due_d     = poll_due_q;
        wait_cnt_d     = wait_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        card_present_d = card_present_q;
        rx_cnt_d       = rx_cnt_q;
        rx_bad_d       = rx_bad_q;
        tx_tvalid      = 1'b0;
        tx_tdata       = 8'h00;
        tx_tdatab      = 4'd0;
        tx_tlast       = 1'b0;
        h_tready       = 1'b0;
        poll_ok        = 1'b0;
        miss_next      = miss_cnt_q;

        rx_end    = bus.rx_tvalid & bus.rx_tend;
        rx_byte   = bus.rx_tvalid & ~bus.rx_tend;
        wait_done = (wait_cnt_q == '0);

        // poll traffic is swallowed; everything else is forwarded one cycle late
        o_tvalid_d = bus.rx_tvalid & (state_q != S_POLL_WAIT);
        o_tdata_d  = bus.rx_tdata;
        o_tdatab_d = bus.rx_tdatab;
        o_tend_d   = bus.rx_tend;
        o_terr_d   = bus.rx_terr;

        case (state_q)
            S_IDLE: begin
                if (poll_cnt_q == '0) begin
                    poll_due_d = 1'b1;
                    poll_cnt_d = POLL_RELOAD;
                end else begin
                    poll_cnt_d = poll_cnt_q - PW'(1);
                end
                if (bus.h_tvalid) begin
                    state_d = S_HOST_TX;
                end else if (poll_due_q && bus.poll_en) begin
                    state_d = S_POLL_TX;
                end
            end
            S_HOST_TX: begin
                tx_tvalid = bus.h_tvalid;
                tx_tdata  = bus.h_tdata;
                tx_tdatab = bus.h_tdatab;
                tx_tlast  = bus.h_tlast;
                h_tready  = bus.tx_tready;
                if (bus.h_tvalid && bus.tx_tready && bus.h_tlast) begin
                    state_d    = S_HOST_WAIT;
                    wait_cnt_d = WAIT_RELOAD;
                end
            end
            S_HOST_WAIT: begin
                if (rx_end || wait_done) begin
                    state_d    = S_IDLE;
                    poll_cnt_d = POLL_RELOAD;
                    // a clean host exchange is proof enough that a card is there
                    if (rx_end && !bus.rx_terr) begin
                        card_present_d = 1'b1;
                        miss_cnt_d     = 4'd0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end
            S_POLL_TX: begin
                tx_tvalid = 1'b1;
                tx_tdata  = 8'h26;
                tx_tdatab = 4'd7;
                tx_tlast  = 1'b1;
                if (bus.tx_tready) begin
                    state_d    = S_POLL_WAIT;
                    poll_due_d = 1'b0;
                    wait_cnt_d = WAIT_RELOAD;
                    rx_cnt_d   = 3'd0;
                    rx_bad_d   = 1'b0;
                end
            end
            S_POLL_WAIT: begin
                if (rx_byte) begin
                    if (rx_cnt_q != 3'd7) begin
                        rx_cnt_d = rx_cnt_q + 3'd1;
                    end
                    if (bus.rx_tdatab != 4'd8) begin
                        rx_bad_d = 1'b1;
                    end
                end
                if (rx_end || wait_done) begin
                    state_d = S_IDLE;
                    // only a clean two-full-byte ATQA counts as a hit
                    poll_ok = rx_end && !bus.rx_terr && (rx_cnt_q == 3'd2) && !rx_bad_q;
                    if (poll_ok) begin
                        card_present_d = 1'b1;
                        miss_cnt_d     = 4'd0;
                    end else begin
                        miss_next  = (miss_cnt_q >= MISS_MAX) ? MISS_MAX : miss_cnt_q + 4'd1;
                        miss_cnt_d = miss_next;
                        if (miss_next == MISS_MAX) begin
                            card_present_d = 1'b0;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            poll_cnt_q     <= POLL_RELOAD;
            poll_due_q     <= 1'b0;
            wait_cnt_q     <= '0;
            miss_cnt_q     <= 4'd0;
            card_present_q <= 1'b0;
            rx_cnt_q       <= 3'd0;
            rx_bad_q       <= 1'b0;
            o_tvalid_q     <= 1'b0;
            o_tdata_q      <= 8'h00;
            o_tdatab_q     <= 4'd0;
            o_tend_q       <= 1'b0;
            o_terr_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            poll_cnt_q     <= poll_cnt_d;
            poll_due_q     <= poll_due_d;
            wait_cnt_q     <= wait_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            card_present_q <= card_present_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bad_q       <= rx_bad_d;
            o_tvalid_q     <= o_tvalid_d;
            o_tdata_q      <= o_tdata_d;
            o_tdatab_q     <= o_tdatab_d;
            o_tend_q       <= o_tend_d;
            o_terr_q       <= o_terr_d;
        end
    end

    assign bus.tx_tvalid    = tx_tvalid;
    assign bus.tx_tdata     = tx_tdata;
    assign bus.tx_tdatab    = tx_tdatab;
    assign bus.tx_tlast     = tx_tlast;
    assign bus.h_tready     = h_tready;
    assign bus.o_tvalid     = o_tvalid_q;
    assign bus.o_tdata      = o_tdata_q;
    assign bus.o_tdatab     = o_tdatab_q;
    assign bus.o_tend       = o_tend_q;
    assign bus.o_terr       = o_terr_q;
    assign bus.card_present = card_present_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_nfca_poll_scheduler.sv
// tb/tb_nfca_poll_scheduler.sv - directed self-checking bench for nfca_poll_scheduler
module tb_nfca_poll_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n;
    int   wcyc;

    nfca_poll_scheduler_if bus ();

    nfca_poll_scheduler #(
        .CLK_FREQ    (1000000),
        .POLL_MS     (1),
        .RESP_TIMEOUT(50),
        .MISS_LIMIT  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_beat(input logic [7:0] d, input logic [3:0] nb, input logic tend, input logic terr);
        bus.rx_tvalid = 1'b1;
        bus.rx_tdata  = d;
        bus.rx_tdatab = nb;
        bus.rx_tend   = tend;
        bus.rx_terr   = terr;
        @(negedge clk);
        chk("poll_rx_hidden", bus.o_tvalid, 0);
        bus.rx_tvalid = 1'b0;
        bus.rx_tend   = 1'b0;
        bus.rx_terr   = 1'b0;
    endtask

    // mode 0: no reply, 1: ATQA, 2: ATQA with error, 3: single byte
    task automatic poll_cycle(input int mode, output int wc);
        int k;
        k = 0;
        while (bus.tx_tvalid !== 1'b1 && k < 1200) begin
            @(negedge clk);
            k++;
        end
        chk("poll_start", bus.tx_tvalid, 1);
        chk("poll_reqa", {bus.tx_tlast, bus.tx_tdatab, bus.tx_tdata}, {1'b1, 4'd7, 8'h26});
        bus.tx_tready = 1'b1;
        @(negedge clk);
        bus.tx_tready = 1'b0;
        chk("poll_wait_txv", bus.tx_tvalid, 0);
        if (mode == 1 || mode == 2) begin
            rx_beat(8'h04, 4'd8, 1'b0, 1'b0);
            rx_beat(8'h00, 4'd8, 1'b0, 1'b0);
            rx_beat(8'h00, 4'd0, 1'b1, (mode == 2));
        end else if (mode == 3) begin
            rx_beat(8'h04, 4'd8, 1'b0, 1'b0);
            rx_beat(8'h00, 4'd0, 1'b1, 1'b0);
        end
        wc = 1;
        while (bus.busy === 1'b1 && wc < 200) begin
            @(negedge clk);
            wc++;
        end
        chk("poll_done", bus.busy, 0);
    endtask

    task automatic host_frame(input logic [7:0] b0, input logic [7:0] b1);
        bus.tx_tready = 1'b1;
        bus.h_tvalid  = 1'b1;
        bus.h_tdata   = b0;
        bus.h_tdatab  = 4'd8;
        bus.h_tlast   = 1'b0;
        @(negedge clk);
        chk("host_busy", bus.busy, 1);
        chk("host_b0", {bus.tx_tvalid, bus.tx_tlast, bus.tx_tdatab, bus.tx_tdata}, {1'b1, 1'b0, 4'd8, b0});
        chk("host_tready", bus.h_tready, 1);
        @(negedge clk);
        bus.h_tdata = b1;
        bus.h_tlast = 1'b1;
        #1;
        chk("host_b1", {bus.tx_tvalid, bus.tx_tlast, bus.tx_tdatab, bus.tx_tdata}, {1'b1, 1'b1, 4'd8, b1});
        @(negedge clk);
        bus.h_tvalid  = 1'b0;
        bus.h_tlast   = 1'b0;
        bus.tx_tready = 1'b0;
        #1;
        chk("host_wait_txv", bus.tx_tvalid, 0);
        chk("host_wait_hrdy", bus.h_tready, 0);
        chk("host_wait_busy", bus.busy, 1);
        bus.rx_tvalid = 1'b1;
        bus.rx_tdata  = 8'h04;
        bus.rx_tdatab = 4'd8;
        @(negedge clk);
        chk("host_rx_fwd", {bus.o_tvalid, bus.o_tdatab, bus.o_tdata}, {1'b1, 4'd8, 8'h04});
        chk("host_rx_busy", bus.busy, 1);
        bus.rx_tdata  = 8'h00;
        bus.rx_tdatab = 4'd0;
        bus.rx_tend   = 1'b1;
        bus.rx_terr   = 1'b0;
        @(negedge clk);
        chk("host_end_fwd", {bus.o_tvalid, bus.o_tend, bus.o_terr}, {1'b1, 1'b1, 1'b0});
        chk("host_end_idle", bus.busy, 0);
        chk("host_end_card", bus.card_present, 1);
        bus.rx_tvalid = 1'b0;
        bus.rx_tend   = 1'b0;
        @(negedge clk);
        chk("host_after_txv", {bus.o_tvalid, bus.tx_tvalid}, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.poll_en   = 1'b0;
        bus.h_tvalid  = 1'b0;
        bus.h_tdata   = 8'h00;
        bus.h_tdatab  = 4'd0;
        bus.h_tlast   = 1'b0;
        bus.tx_tready = 1'b0;
        bus.rx_tvalid = 1'b0;
        bus.rx_tdata  = 8'h00;
        bus.rx_tdatab = 4'd0;
        bus.rx_tend   = 1'b0;
        bus.rx_terr   = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_txv", bus.tx_tvalid, 0);
        chk("rst_hrdy", bus.h_tready, 0);
        chk("rst_ov", bus.o_tvalid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_card", bus.card_present, 0);
        rst = 1'b0;

        // T1 host frame with polling disabled
        @(negedge clk);
        host_frame(8'h93, 8'h20);

        // T2 poll hit: REQA after 1001 idle cycles from reset release
        rst = 1'b1;
        bus.poll_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_rst_card", bus.card_present, 0);
        rst = 1'b0;
        n = 0;
        while (bus.tx_tvalid !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("t2_poll_time", n, 1001);
        repeat (2) @(negedge clk);
        chk("t2_hold", {bus.tx_tvalid, bus.tx_tlast, bus.tx_tdatab, bus.tx_tdata}, {1'b1, 1'b1, 4'd7, 8'h26});
        poll_cycle(1, wcyc);
        chk("t2_card", bus.card_present, 1);
        chk("t2_hidden", bus.o_tvalid, 0);

        // T3 three missed polls clear presence only on the third
        poll_cycle(0, wcyc);
        chk("t3_timeout_len", wcyc, 51);
        chk("t3_miss1_card", bus.card_present, 1);
        poll_cycle(0, wcyc);
        chk("t3_miss2_card", bus.card_present, 1);
        poll_cycle(0, wcyc);
        chk("t3_miss3_card", bus.card_present, 0);

        // T4 error and short replies count as misses
        poll_cycle(1, wcyc);
        chk("t4_hit_card", bus.card_present, 1);
        poll_cycle(2, wcyc);
        chk("t4_terr_card", bus.card_present, 1);
        poll_cycle(3, wcyc);
        chk("t4_short_card", bus.card_present, 1);
        poll_cycle(0, wcyc);
        chk("t4_third_card", bus.card_present, 0);

        // T5 host wins over a pending poll
        bus.poll_en = 1'b0;
        repeat (1100) @(negedge clk);
        chk("t5_no_poll", bus.busy, 0);
        bus.poll_en  = 1'b1;
        bus.h_tvalid = 1'b1;
        bus.h_tdata  = 8'h52;
        bus.h_tdatab = 4'd7;
        bus.h_tlast  = 1'b1;
        @(negedge clk);
        chk("t5_host_first", {bus.tx_tvalid, bus.tx_tlast, bus.tx_tdatab, bus.tx_tdata}, {1'b1, 1'b1, 4'd7, 8'h52});
        @(negedge clk);
        chk("t5_host_held", {bus.tx_tvalid, bus.tx_tdata}, {1'b1, 8'h52});
        bus.tx_tready = 1'b1;
        @(negedge clk);
        bus.h_tvalid  = 1'b0;
        bus.h_tlast   = 1'b0;
        bus.tx_tready = 1'b0;
        #1;
        chk("t5_host_wait", {bus.busy, bus.tx_tvalid}, {1'b1, 1'b0});
        bus.rx_tvalid = 1'b1;
        bus.rx_tend   = 1'b1;
        bus.rx_terr   = 1'b0;
        @(negedge clk);
        bus.rx_tvalid = 1'b0;
        bus.rx_tend   = 1'b0;
        chk("t5_host_done", bus.card_present, 1);
        poll_cycle(1, wcyc);
        chk("t5_poll_card", bus.card_present, 1);

        // T6 reset while a REQA is stalled
        n = 0;
        while (bus.tx_tvalid !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_poll", {bus.busy, bus.tx_tdata}, {1'b1, 8'h26});
        rst = 1'b1;
        @(negedge clk);
        chk("t6_txv", bus.tx_tvalid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_card", bus.card_present, 0);
        rst = 1'b0;
        host_frame(8'h30, 8'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
